// File: rtl/step_counter_monitor.sv
// Receive-side checker for counter streams: each valid sample must equal the
// previous sample plus the step reported with it; tracks lock, matches and errors.
module step_counter_monitor #(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int ERR_LIMIT = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_step,
    output logic             locked,
    output logic             fail,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] match_count,
    output logic [WIDTH-1:0] last_data
);

    // state  | meaning
    // S_IDLE | waiting for the first sample to seed last_data
    // S_ACQ  | seeded; waiting for one matching step to lock
    // S_LOCK | locked; mismatches are counted as errors
    // S_FAIL | ERR_LIMIT consecutive mismatches seen; frozen until clr/RST
    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK, S_FAIL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [3:0]       ERR_LIM = 4'(ERR_LIMIT);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic [WIDTH-1:0] last_data_q, last_data_d;
    logic [3:0]       cons_err_q, cons_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [WIDTH-1:0] expected;
    logic             is_match;

    // Sum truncated to WIDTH bits so wrap-around counts as a match.
    assign expected = last_data_q + in_step;
    assign is_match = (in_data == expected);

    always_comb begin
        state_d       = state_q;
        err_count_d   = err_count_q;
        match_count_d = match_count_q;
        last_data_d   = last_data_q;
        cons_err_d    = cons_err_q;
        err_pulse_d   = 1'b0;
        if (clr) begin
            state_d       = S_IDLE;
            err_count_d   = '0;
            match_count_d = '0;
            last_data_d   = '0;
            cons_err_d    = '0;
        end else if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    last_data_d = in_data;
                    state_d     = S_ACQ;
                end
                S_ACQ: begin
                    last_data_d = in_data;
                    if (is_match) begin
                        if (match_count_q != CNT_MAX) match_count_d = match_count_q + 1'b1;
                        state_d = S_LOCK;
                    end
                end
                S_LOCK: begin
                    last_data_d = in_data;
                    if (is_match) begin
                        if (match_count_q != CNT_MAX) match_count_d = match_count_q + 1'b1;
                        cons_err_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
                        cons_err_d = cons_err_q + 1'b1;
                        if (cons_err_d >= ERR_LIM) state_d = S_FAIL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= S_IDLE;
            err_count_q   <= '0;
            match_count_q <= '0;
            last_data_q   <= '0;
            cons_err_q    <= '0;
            err_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_count_q   <= err_count_d;
            match_count_q <= match_count_d;
            last_data_q   <= last_data_d;
            cons_err_q    <= cons_err_d;
            err_pulse_q   <= err_pulse_d;
        end
    end

    assign locked      = (state_q == S_LOCK);
    assign fail        = (state_q == S_FAIL);
    assign err_pulse   = err_pulse_q;
    assign err_count   = err_count_q;
    assign match_count = match_count_q;
    assign last_data   = last_data_q;

endmodule

// File: tb/tb_step_counter_monitor.sv
// Directed bench for step_counter_monitor; a second CNT_W=2 instance shares the
// stimulus to exercise counter saturation.
module tb_step_counter_monitor;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic [7:0] in_step = '0;
    logic       locked, fail, err_pulse;
    logic [7:0] err_count, match_count, last_data;
    logic       locked2, fail2, err_pulse2;
    logic [1:0] err_count2, match_count2;
    logic [7:0] last_data2;
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    step_counter_monitor #(.WIDTH(8), .CNT_W(8), .ERR_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_step(in_step), .locked(locked), .fail(fail), .err_pulse(err_pulse),
        .err_count(err_count), .match_count(match_count), .last_data(last_data));

    step_counter_monitor #(.WIDTH(8), .CNT_W(2), .ERR_LIMIT(4)) dut_sat (
        .CLK(CLK), .RST(RST), .clr(clr), .in_valid(in_valid), .in_data(in_data),
        .in_step(in_step), .locked(locked2), .fail(fail2), .err_pulse(err_pulse2),
        .err_count(err_count2), .match_count(match_count2), .last_data(last_data2));

    // Apply one cycle of stimulus, sample 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic [7:0] s);
        in_valid = v; in_data = d; in_step = s;
        @(posedge CLK); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%0b exp=0", locked); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL rst_fail got=%0b exp=0", fail); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL rst_err_pulse got=%0b exp=0", err_pulse); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rst_err_count got=%0d exp=0", err_count); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL rst_match_count got=%0d exp=0", match_count); end
        total++; if (last_data !== 8'd0) begin bad++; $display("FAIL rst_last_data got=%0d exp=0", last_data); end
        @(negedge CLK); RST = 1'b0;
    endtask

    task automatic test_acquire;
        step(1'b1, 8'd10, 8'd77);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL acq_first_locked got=%0b exp=0", locked); end
        total++; if (last_data !== 8'd10) begin bad++; $display("FAIL acq_first_last got=%0d exp=10", last_data); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL acq_first_match got=%0d exp=0", match_count); end
        step(1'b1, 8'd13, 8'd3);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL acq_lock got=%0b exp=1", locked); end
        total++; if (match_count !== 8'd1) begin bad++; $display("FAIL acq_match1 got=%0d exp=1", match_count); end
        step(1'b1, 8'd16, 8'd3);
        total++; if (match_count !== 8'd2) begin bad++; $display("FAIL acq_match2 got=%0d exp=2", match_count); end
        total++; if (last_data !== 8'd16) begin bad++; $display("FAIL acq_last16 got=%0d exp=16", last_data); end
        total++; if (match_count2 !== 2'd2) begin bad++; $display("FAIL sat_match2 got=%0d exp=2", match_count2); end
    endtask

    task automatic test_single_error;
        step(1'b1, 8'd20, 8'd3);
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL err_pulse_hi got=%0b exp=1", err_pulse); end
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL err_count1 got=%0d exp=1", err_count); end
        total++; if (last_data !== 8'd20) begin bad++; $display("FAIL err_last20 got=%0d exp=20", last_data); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL err_still_locked got=%0b exp=1", locked); end
        step(1'b1, 8'd23, 8'd3);
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL err_pulse_one_cycle got=%0b exp=0", err_pulse); end
        total++; if (match_count !== 8'd3) begin bad++; $display("FAIL recover_match3 got=%0d exp=3", match_count); end
        // Three more mismatches must not fail if the recovery match cleared the run.
        step(1'b1, 8'd50, 8'd1);
        step(1'b1, 8'd60, 8'd1);
        step(1'b1, 8'd70, 8'd1);
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL cons_reset_fail got=%0b exp=0", fail); end
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL cons_reset_locked got=%0b exp=1", locked); end
        total++; if (err_count !== 8'd4) begin bad++; $display("FAIL err_count4 got=%0d exp=4", err_count); end
        step(1'b1, 8'd71, 8'd1);
        total++; if (match_count !== 8'd4) begin bad++; $display("FAIL match4 got=%0d exp=4", match_count); end
    endtask

    task automatic test_wrap;
        step(1'b1, 8'd254, 8'd183);
        total++; if (match_count !== 8'd5) begin bad++; $display("FAIL wrap_pre_match got=%0d exp=5", match_count); end
        step(1'b1, 8'd1, 8'd3);
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL wrap_err_pulse got=%0b exp=0", err_pulse); end
        total++; if (match_count !== 8'd6) begin bad++; $display("FAIL wrap_match got=%0d exp=6", match_count); end
        total++; if (err_count !== 8'd4) begin bad++; $display("FAIL wrap_err_count got=%0d exp=4", err_count); end
        total++; if (match_count2 !== 2'd3) begin bad++; $display("FAIL sat_match_hold got=%0d exp=3", match_count2); end
    endtask

    task automatic test_gap;
        for (int i = 0; i < 3; i++) step(1'b0, 8'd99, 8'd5);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL gap_locked got=%0b exp=1", locked); end
        total++; if (match_count !== 8'd6) begin bad++; $display("FAIL gap_match got=%0d exp=6", match_count); end
        total++; if (last_data !== 8'd1) begin bad++; $display("FAIL gap_last got=%0d exp=1", last_data); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL gap_err_pulse got=%0b exp=0", err_pulse); end
    endtask

    task automatic test_fail;
        step(1'b1, 8'd100, 8'd0);
        step(1'b1, 8'd101, 8'd0);
        step(1'b1, 8'd102, 8'd0);
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL fail_early got=%0b exp=0", fail); end
        step(1'b1, 8'd103, 8'd0);
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL fail_set got=%0b exp=1", fail); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL fail_unlocked got=%0b exp=0", locked); end
        total++; if (err_count !== 8'd8) begin bad++; $display("FAIL fail_err_count got=%0d exp=8", err_count); end
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL fail_last_pulse got=%0b exp=1", err_pulse); end
        total++; if (err_count2 !== 2'd3) begin bad++; $display("FAIL sat_err_hold got=%0d exp=3", err_count2); end
        step(1'b1, 8'd104, 8'd1);
        step(1'b1, 8'd7, 8'd9);
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL fail_sticky got=%0b exp=1", fail); end
        total++; if (match_count !== 8'd6) begin bad++; $display("FAIL fail_match_hold got=%0d exp=6", match_count); end
        total++; if (err_count !== 8'd8) begin bad++; $display("FAIL fail_err_hold got=%0d exp=8", err_count); end
        total++; if (last_data !== 8'd103) begin bad++; $display("FAIL fail_last_hold got=%0d exp=103", last_data); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL fail_no_pulse got=%0b exp=0", err_pulse); end
    endtask

    task automatic test_clr;
        clr = 1'b1;
        step(1'b1, 8'd55, 8'd0);
        clr = 1'b0;
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL clr_fail got=%0b exp=0", fail); end
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL clr_locked got=%0b exp=0", locked); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL clr_err_count got=%0d exp=0", err_count); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL clr_match_count got=%0d exp=0", match_count); end
        total++; if (last_data !== 8'd0) begin bad++; $display("FAIL clr_priority_last got=%0d exp=0", last_data); end
        step(1'b1, 8'd7, 8'd0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL clr_idle_to_acq got=%0b exp=0", locked); end
        total++; if (last_data !== 8'd7) begin bad++; $display("FAIL clr_seed got=%0d exp=7", last_data); end
        step(1'b1, 8'd9, 8'd2);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL clr_relock got=%0b exp=1", locked); end
        total++; if (match_count !== 8'd1) begin bad++; $display("FAIL clr_relock_match got=%0d exp=1", match_count); end
    endtask

    task automatic test_async_reset;
        step(1'b1, 8'd5, 8'd1);
        #3; RST = 1'b1; #1;
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL arst_locked got=%0b exp=0", locked); end
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL arst_err_count got=%0d exp=0", err_count); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL arst_match_count got=%0d exp=0", match_count); end
        total++; if (last_data !== 8'd0) begin bad++; $display("FAIL arst_last got=%0d exp=0", last_data); end
        #2; RST = 1'b0;
        step(1'b1, 8'd30, 8'd0);
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL arst_acq_locked got=%0b exp=0", locked); end
        total++; if (last_data !== 8'd30) begin bad++; $display("FAIL arst_acq_last got=%0d exp=30", last_data); end
        step(1'b1, 8'd31, 8'd1);
        total++; if (locked !== 1'b1) begin bad++; $display("FAIL arst_relock got=%0b exp=1", locked); end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_single_error();
        test_wrap();
        test_gap();
        test_fail();
        test_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/step_counter_monitor.md
Name: step_counter_monitor

Overview:
- Receive-side checker for the free-running counter streams that our counter blocks produce.
- Each valid sample is compared against the previous sample plus the step the producer reports for that sample.
- The block acquires lock, counts matches and mismatches, and declares failure after a run of consecutive mismatches.
- It sits beside a counter producer in the test designs as its consumer/monitor.

Parameters:
- WIDTH, 8, width of the sample and step values; all sample arithmetic is modulo 2^WIDTH.
- CNT_W, 8, width of the match and error counters.
- ERR_LIMIT, 4, number of consecutive mismatches in LOCK that forces FAIL (legal range 1..15).

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state immediately.
- clr  input  1  synchronous clear; returns the block to IDLE and zeroes the counters.
- in_valid  input  1  qualifies in_data and in_step this cycle.
- in_data  input  WIDTH  sample from the producer.
- in_step  input  WIDTH  increment the producer applied to reach this sample.
- locked  output  1  high while the state is LOCK.
- fail  output  1  high while the state is FAIL.
- err_pulse  output  1  one-cycle pulse after a mismatch detected in LOCK.
- err_count  output  CNT_W  total LOCK mismatches; saturating.
- match_count  output  CNT_W  total matches in ACQ and LOCK; saturating.
- last_data  output  WIDTH  last accepted sample.

Behaviour:
- Reset: while RST=1 the state is IDLE and every output is 0 (locked, fail, err_pulse, err_count, match_count, last_data). The internal consecutive-error counter is also 0. Reset takes effect asynchronously; RST asserted mid-operation aborts any state immediately.
- All outputs are registered. Latency is 1 cycle: the response to a sample appears after the edge that samples it.
- Mismatch test: a sample matches when in_data == (last_data + in_step) mod 2^WIDTH. Carries out of the WIDTH bits are discarded, so wrap-around is legal.
- Cycles with in_valid=0: no state change, counters hold, err_pulse=0.
- clr=1: on the next edge the block goes to IDLE, clears both counters, last_data and the consecutive-error counter. clr has priority over in_valid in the same cycle, and it works from every state.
- err_pulse defaults to 0 on every cycle; only the LOCK mismatch case sets it.
- State machine:
  - IDLE: on a valid sample, last_data <= in_data and the state goes to ACQ. No comparison is made.
  - ACQ:
    - Match: match_count++, last_data <= in_data, go to LOCK.
    - Mismatch: last_data <= in_data (resync), stay in ACQ. No error is counted and err_pulse stays 0.
  - LOCK:
    - Match: match_count++, consecutive-error counter <= 0, last_data <= in_data.
    - Mismatch:
      - err_pulse=1 for exactly one cycle, err_count++, consecutive-error counter++, last_data <= in_data.
      - If the consecutive-error counter reaches ERR_LIMIT, go to FAIL (locked=0, fail=1 after the same edge). That final mismatch still raises err_pulse and increments err_count.
  - FAIL: all samples are ignored and counters hold. Only clr or RST leaves FAIL.
- Saturation: match_count and err_count stop at 2^CNT_W-1 and never wrap.
- Back-to-back valid samples on every cycle must be handled with no bubbles.

Test Plan:
- Reset: assert RST asynchronously between edges while in LOCK with nonzero counts -> all outputs read 0 before the next edge; after release, the first valid sample enters ACQ.
- Acquire/lock (WIDTH=8): samples 10 (step x), 13 (step 3), 16 (step 3) -> locked=1 after the edge sampling 13; match_count=2 after 16; last_data=16.
- Wrap-around: in LOCK with last_data=254, sample 1 with step 3 -> match, no err_pulse, match_count increments.
- Single error and recovery: in LOCK with last_data=16, sample 20 with step 3 -> err_pulse high for exactly 1 cycle, err_count=1, last_data=20. Then sample 23 with step 3 -> match, and the consecutive-error counter resets.
- Fail: 4 consecutive mismatches in LOCK -> fail=1, locked=0, err_count=4. Further valid samples change nothing. clr -> IDLE with all counters 0.
- Corner cases:
  - clr and in_valid in the same cycle -> clr wins and the sample is not captured.
  - CNT_W=2 with 5 matches -> match_count holds at 3.
  - Gaps in in_valid between samples -> state and counters are unchanged during the gaps.
